// File: rtl/param_shadow_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_shadow_bank                                            |
// | Description : Double-buffered parameter memory. SPI accesses the shadow   |
// |               bank, the DSP reads the active bank; banks swap on a frame   |
// |               boundary and the new shadow resyncs in the background.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_shadow_bank #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_enable,
    input  logic                  commit,
    input  logic                  frame_tick,
    input  logic [ADDR_WIDTH-1:0] dsp_rd_addr,
    output logic [WORD_WIDTH-1:0] dsp_rd_data,
    output logic                  active_bank,
    output logic                  commit_pending,
    output logic                  busy
);

    localparam int                    c_NUM_ADDRS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [0:0]            c_ST_IDLE   = 1'b0;
    localparam logic [0:0]            c_ST_SYNC   = 1'b1;

    // Storage is deliberately outside the reset domain; it powers up cleared.
    logic [WORD_WIDTH-1:0] r_bank [2][c_NUM_ADDRS] = '{default: '0};

    logic [0:0]             r_state;
    logic                   r_active;
    logic                   r_pending;
    logic [c_NUM_ADDRS-1:0] r_dirty;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic [WORD_WIDTH-1:0]  r_rd_data;
    logic [WORD_WIDTH-1:0]  r_dsp_rd_data;

    logic                   w_shadow;
    logic [0:0]             w_state_nxt;
    logic                   w_active_nxt;
    logic                   w_pending_nxt;
    logic [c_NUM_ADDRS-1:0] w_dirty_nxt;
    logic [ADDR_WIDTH-1:0]  w_cnt_nxt;
    logic                   w_copy;
    logic                   w_fwd;

    assign w_shadow = ~r_active;

    // Uncopied, unwritten shadow words are still stale: serve them from active.
    assign w_fwd = (r_state == c_ST_SYNC) && (rd_addr >= r_cnt) && !r_dirty[rd_addr];

    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending | commit;
        w_dirty_nxt   = r_dirty;
        w_cnt_nxt     = r_cnt;
        w_copy        = 1'b0;
        if (wr_enable) begin
            w_dirty_nxt[wr_addr] = 1'b1;
        end
        case (r_state)
            c_ST_IDLE: begin
                if (frame_tick && (r_pending || commit)) begin
                    w_state_nxt   = c_ST_SYNC;
                    w_active_nxt  = ~r_active;
                    w_pending_nxt = 1'b0;
                    w_dirty_nxt   = '0;
                    w_cnt_nxt     = '0;
                end
            end
            c_ST_SYNC: begin
                // The SPI write owns the shadow write port, so it stalls the copy.
                if (!wr_enable) begin
                    w_copy = !r_dirty[r_cnt];
                    if (r_cnt == c_LAST_ADDR) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_active      <= 1'b0;
            r_pending     <= 1'b0;
            r_dirty       <= '0;
            r_cnt         <= '0;
            r_rd_data     <= '0;
            r_dsp_rd_data <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_active      <= w_active_nxt;
            r_pending     <= w_pending_nxt;
            r_dirty       <= w_dirty_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rd_data     <= w_fwd ? r_bank[r_active][rd_addr] : r_bank[w_shadow][rd_addr];
            r_dsp_rd_data <= r_bank[r_active][dsp_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_enable) begin
                r_bank[w_shadow][wr_addr] <= wr_data;
            end
            if (w_copy) begin
                r_bank[w_shadow][r_cnt] <= r_bank[r_active][r_cnt];
            end
        end
    end

    assign rd_data        = r_rd_data;
    assign dsp_rd_data    = r_dsp_rd_data;
    assign active_bank    = r_active;
    assign commit_pending = r_pending;
    assign busy           = (r_state == c_ST_SYNC);

endmodule
`default_nettype wire

// File: tb/tb_param_shadow_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_param_shadow_bank                                         |
// | Description : Scoreboard bench for param_shadow_bank against a bank model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_param_shadow_bank;

    localparam int c_WW = 8;
    localparam int c_AW = 2;
    localparam int c_N  = 1 << c_AW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [c_AW-1:0] rd_addr = '0;
    logic [c_WW-1:0] rd_data;
    logic [c_AW-1:0] wr_addr = '0;
    logic [c_WW-1:0] wr_data = '0;
    logic            wr_enable = 1'b0;
    logic            commit = 1'b0;
    logic            frame_tick = 1'b0;
    logic [c_AW-1:0] dsp_rd_addr = '0;
    logic [c_WW-1:0] dsp_rd_data;
    logic            active_bank;
    logic            commit_pending;
    logic            busy;

    param_shadow_bank #(.WORD_WIDTH(c_WW), .ADDR_WIDTH(c_AW)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .commit(commit), .frame_tick(frame_tick),
        .dsp_rd_addr(dsp_rd_addr), .dsp_rd_data(dsp_rd_data),
        .active_bank(active_bank), .commit_pending(commit_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_WW-1:0] rd;
        logic [c_WW-1:0] dsp;
        logic            act;
        logic            pend;
        logic            busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: physical banks, which bank is live, words written since
    // the last swap, and the list of addresses the background copy still owes.
    logic [c_WW-1:0] m_bank [2][c_N] = '{default: '0};
    int              m_act = 0;
    bit              m_pend = 0;
    bit              m_written [c_N] = '{default: 0};
    int              copy_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit still_owed(input int a);
        bit found = 0;
        foreach (copy_q[k]) if (copy_q[k] == a) found = 1;
        return found;
    endfunction

    task automatic model_edge();
        exp_t e;
        int   sh;
        int   a;
        bit   was_idle;
        e = '0;
        if (reset) begin
            m_act = 0;
            m_pend = 0;
            foreach (m_written[k]) m_written[k] = 0;
            copy_q.delete();
        end else begin
            sh = 1 - m_act;
            was_idle = (copy_q.size() == 0);
            e.dsp = m_bank[m_act][int'(dsp_rd_addr)];
            a = int'(rd_addr);
            if (!was_idle && still_owed(a) && !m_written[a]) e.rd = m_bank[m_act][a];
            else e.rd = m_bank[sh][a];
            if (!was_idle && !wr_enable) begin
                a = copy_q.pop_front();
                if (!m_written[a]) m_bank[sh][a] = m_bank[m_act][a];
            end
            if (wr_enable) begin
                m_bank[sh][int'(wr_addr)] = wr_data;
                m_written[int'(wr_addr)] = 1;
            end
            if (commit) m_pend = 1;
            if (was_idle && frame_tick && m_pend) begin
                m_act = sh;
                m_pend = 0;
                foreach (m_written[k]) m_written[k] = 0;
                for (int k = 0; k < c_N; k++) copy_q.push_back(k);
            end
            e.act  = m_act[0];
            e.pend = m_pend;
            e.busy = (copy_q.size() != 0);
        end
        sb.push_back(e);
    endtask

    // One clock cycle: inputs change on the falling edge, model follows the rising edge.
    task automatic drive(input logic r = 0, input logic we = 0, input logic [c_AW-1:0] wa = 0,
                         input logic [c_WW-1:0] wd = 0, input logic cm = 0, input logic ft = 0,
                         input logic [c_AW-1:0] ra = 0, input logic [c_AW-1:0] da = 0);
        @(negedge clk);
        reset = r; wr_enable = we; wr_addr = wa; wr_data = wd;
        commit = cm; frame_tick = ft; rd_addr = ra; dsp_rd_addr = da;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) drive();
        chk("sync_done", 32'(busy), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("rd_data",        32'(rd_data),        32'(mon_e.rd));
            chk("dsp_rd_data",    32'(dsp_rd_data),    32'(mon_e.dsp));
            chk("active_bank",    32'(active_bank),    32'(mon_e.act));
            chk("commit_pending", 32'(commit_pending), 32'(mon_e.pend));
            chk("busy",           32'(busy),           32'(mon_e.busy));
        end
    end

    initial begin
        int n;
        logic [c_WW-1:0] vals [c_N];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) drive(1);
        chk("reset_dsp", 32'(dsp_rd_data), 32'd0);

        for (int i = 0; i < c_N; i++) drive(0, 1, c_AW'(i), vals[i], 0, 0, 0, c_AW'(i));
        drive(0, 0, 0, 0, 0, 0, 2'd2, 2'd2);
        chk("spi_read_a2", 32'(rd_data), 32'h33);
        chk("dsp_still_zero", 32'(dsp_rd_data), 32'd0);

        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive();
        chk("pending_before_tick", 32'(commit_pending), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        chk("swap_active", 32'(active_bank), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            n++;
            drive(0, 0, 0, 0, 0, 0, 0, c_AW'(i));
        end
        chk("busy_len_plain", 32'(n), 32'd4);
        for (int i = 0; i < c_N; i++) begin
            drive(0, 0, 0, 0, 0, 0, c_AW'(i), c_AW'(i));
            chk("resynced_shadow", 32'(rd_data), 32'(vals[i]));
            chk("dsp_after_swap", 32'(dsp_rd_data), 32'(vals[i]));
        end

        drive(0, 0, 0, 0, 1, 1);
        chk("same_cycle_pending", 32'(commit_pending), 32'd0);
        chk("same_cycle_active", 32'(active_bank), 32'd0);
        wait_idle();

        drive(0, 1, 2'd2, 8'h66);
        drive(0, 0, 0, 0, 1, 1);
        n = 1;
        drive();
        n++;
        drive(0, 1, 2'd3, 8'h99, 0, 0, 2'd2);
        chk("forward_active", 32'(rd_data), 32'h66);
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            n++;
            drive();
        end
        chk("busy_len_stall", 32'(n), 32'd5);
        drive(0, 0, 0, 0, 0, 0, 2'd3);
        chk("write_survives_copy", 32'(rd_data), 32'h99);

        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("tick_in_sync_ignored", 32'(active_bank), 32'd0);
        wait_idle();
        drive(0, 0, 0, 0, 0, 1);
        chk("pending_serviced", 32'(active_bank), 32'd1);
        wait_idle();

        drive(0, 0, 0, 0, 1, 1);
        drive();
        drive();
        drive(1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_active", 32'(active_bank), 32'd0);
        for (int i = 0; i < c_N; i++) drive(0, 0, 0, 0, 0, 0, c_AW'(i), c_AW'(i));

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(2) == 0, c_AW'($urandom), c_WW'($urandom),
                  $urandom_range(9) == 0, $urandom_range(7) == 0, c_AW'($urandom), c_AW'($urandom));
        end
        drive();
        #3;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
